// File: rtl/sync_fsm_pkg.sv
// Shared definitions for the synchronization-block main FSM and its self-test sequencer.
package sync_fsm_pkg;

  typedef enum logic [7:0] {
    IDLE              = 8'd0,
    FG_WAIT_OPTO      = 8'd1,
    FG_WAIT_OPEN      = 8'd2,
    WAIT_PHASE_FRONT  = 8'd3,
    WAIT_PHASE_DELAY  = 8'd4,
    TRIGGER_PROLONG   = 8'd5,
    DETECTOR_BUSY     = 8'd6,
    DETECTOR_WAIT     = 8'd7,
    DETECTOR_FINISHED = 8'd8
  } main_state_e;

  localparam int MAIN_N_STATES = 9;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_LOOP   = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;

  // 10 us per state at the nominal 100 MHz clock.
  localparam int DEFAULT_DWELL = 1000;

  typedef enum logic [1:0] {
    C_IDLE,
    C_DWELL,
    C_HOLD,
    C_DONE
  } ctrl_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; tc is high in the last enabled cycle of each dwell and reloads itself.
module dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] reload,
  output logic               tc
);

  logic [DWELL_W-1:0] count;

  assign tc = en && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load || tc) begin
      count <= reload;
    end else if (en) begin
      count <= count - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/fsm_self_test_seq.sv
// Self-test sequencer: walks state_out over a programmable code range in SINGLE, LOOP or STEP mode.
module fsm_self_test_seq
  import sync_fsm_pkg::*;
#(
  parameter int STATE_W = 8,
  parameter int N_STEPS = MAIN_N_STATES,
  parameter int DWELL_W = 24,
  parameter int LOOP_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [STATE_W-1:0] first_step,
  input  logic [STATE_W-1:0] last_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               step_req,
  output logic [STATE_W-1:0] state_out,
  output logic               step_stb,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LOOP_W-1:0]  loop_cnt
);

  localparam logic [STATE_W-1:0] LAST_CODE = STATE_W'(N_STEPS - 1);

  ctrl_state_e        state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [STATE_W-1:0] first_q, first_d;
  logic [STATE_W-1:0] last_q, last_d;
  logic [DWELL_W-1:0] reload_q, reload_d, reload_new;
  logic [STATE_W-1:0] code_d;
  logic [LOOP_W-1:0]  loop_d;
  logic               stb_d, busy_d, done_d, err_d;
  logic               range_ok, can_start, advance, timer_load, timer_tc;

  assign range_ok   = (first_step <= last_step) && (last_step <= LAST_CODE);
  assign can_start  = (state_q == C_IDLE) || (state_q == C_DONE);
  assign reload_new = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .en      (state_q == C_DWELL),
    .reload  (timer_load ? reload_new : reload_q),
    .tc      (timer_tc)
  );

  // NOTE: every signal gets a default before the branches, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    first_d    = first_q;
    last_d     = last_q;
    reload_d   = reload_q;
    code_d     = state_out;
    loop_d     = loop_cnt;
    stb_d      = 1'b0;
    busy_d     = busy;
    done_d     = done;
    err_d      = 1'b0;
    timer_load = 1'b0;
    advance    = 1'b0;

    if (stop) begin
      // Abort leaves done as it was; a stop in idle has nothing to abort.
      if (state_q != C_IDLE) begin
        state_d = C_IDLE;
        code_d  = '0;
        busy_d  = 1'b0;
      end
    end else if (start && can_start) begin
      if (range_ok) begin
        mode_d     = mode;
        first_d    = first_step;
        last_d     = last_step;
        reload_d   = reload_new;
        code_d     = first_step;
        stb_d      = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        loop_d     = '0;
        timer_load = 1'b1;
        state_d    = (mode == MODE_STEP) ? C_HOLD : C_DWELL;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        C_DWELL: advance = timer_tc;
        C_HOLD:  advance = step_req;
        default: advance = 1'b0;
      endcase
    end

    if (advance) begin
      if (state_out < last_q) begin
        code_d = state_out + STATE_W'(1);
        stb_d  = 1'b1;
      end else if (mode_q == MODE_LOOP) begin
        code_d = first_q;
        stb_d  = 1'b1;
        if (loop_cnt != '1) loop_d = loop_cnt + LOOP_W'(1);
      end else begin
        state_d = C_DONE;
        code_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= C_IDLE;
      mode_q    <= MODE_SINGLE;
      first_q   <= '0;
      last_q    <= '0;
      reload_q  <= '0;
      state_out <= '0;
      step_stb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      loop_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      first_q   <= first_d;
      last_q    <= last_d;
      reload_q  <= reload_d;
      state_out <= code_d;
      step_stb  <= stb_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      loop_cnt  <= loop_d;
    end
  end

endmodule

// File: tb/tb_fsm_self_test_seq.sv
// Scoreboard bench: expected state codes are queued at stimulus time and checked on each step_stb.
module tb_fsm_self_test_seq;
  import sync_fsm_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, step_req = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  first_step = '0, last_step = '0;
  logic [23:0] dwell = '0;

  logic [7:0]  state_out, state_out_s;
  logic        step_stb, busy, done, err;
  logic        step_stb_s, busy_s, done_s, err_s;
  logic [15:0] loop_cnt;
  logic [1:0]  loop_cnt_s;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int stb_count = 0;
  int prev_stb = -1;
  int exp_gap = 0;
  logic [7:0] exp_q[$];

  fsm_self_test_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .first_step(first_step), .last_step(last_step), .dwell(dwell), .step_req(step_req),
    .state_out(state_out), .step_stb(step_stb), .busy(busy), .done(done), .err(err),
    .loop_cnt(loop_cnt)
  );

  fsm_self_test_seq #(.LOOP_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .first_step(first_step), .last_step(last_step), .dwell(dwell), .step_req(step_req),
    .state_out(state_out_s), .step_stb(step_stb_s), .busy(busy_s), .done(done_s), .err(err_s),
    .loop_cnt(loop_cnt_s)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Monitor: each strobe pops one expected code and, when armed, checks the dwell gap.
  always @(negedge clock) begin
    if (step_stb) begin
      logic [7:0] exp_code;
      stb_count++;
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_stb: state_out=%0d with no code expected", state_out);
      end else begin
        exp_code = exp_q.pop_front();
        if (state_out !== exp_code) begin
          fails++;
          $display("FAIL stb_code: got %0d expected %0d", state_out, exp_code);
        end
      end
      if (prev_stb >= 0 && exp_gap > 0) begin
        tests_run++;
        if (cyc - prev_stb != exp_gap) begin
          fails++;
          $display("FAIL dwell_gap: got %0d cycles expected %0d", cyc - prev_stb, exp_gap);
        end
      end
      prev_stb = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] f, input logic [7:0] l,
                        input logic [23:0] d);
    mode = m; first_step = f; last_step = l; dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({state_out, step_stb, busy, done, err, loop_cnt, loop_cnt_s} !== '0) begin
      fails++;
      $display("FAIL %s: state=%0d stb=%b busy=%b done=%b err=%b loop=%0d loop_s=%0d, all 0 expected",
               name, state_out, step_stb, busy, done, err, loop_cnt, loop_cnt_s);
    end
  endtask

  task automatic wait_done(input string name, input int expected);
    int n = 0;
    while (!done && n < 20000) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != expected) begin
      fails++;
      $display("FAIL %s: done after %0d cycles expected %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s0;
    exp_gap = DEFAULT_DWELL; prev_stb = -1;
    for (int i = 0; i <= 8; i++) exp_q.push_back(8'(i));
    s0 = stb_count;
    launch(MODE_SINGLE, 8'd0, 8'd8, 24'(DEFAULT_DWELL));
    tests_run++;
    if (state_out !== 8'd0 || busy !== 1'b1 || step_stb !== 1'b1) begin
      fails++;
      $display("FAIL single_first: state=%0d busy=%b stb=%b expected 0/1/1", state_out, busy, step_stb);
    end
    // Nine codes at 1000 cycles each; done is visible in cycle 9001 counting the start edge as 1.
    wait_done("single_len", 9000);
    tests_run++;
    if (state_out !== 8'd0 || busy !== 1'b0 || stb_count - s0 != 9 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_end: state=%0d busy=%b stbs=%0d pending=%0d expected 0/0/9/0",
               state_out, busy, stb_count - s0, exp_q.size());
    end
  endtask

  task automatic test_loop();
    exp_gap = 2; prev_stb = -1;
    for (int p = 0; p < 4; p++)
      for (int c = 3; c <= 5; c++) exp_q.push_back(8'(c));
    exp_q.push_back(8'd3);
    launch(MODE_LOOP, 8'd3, 8'd5, 24'd2);
    repeat (24) tick();
    tests_run++;
    if (loop_cnt !== 16'd4 || state_out !== 8'd3) begin
      fails++;
      $display("FAIL loop_count: loop_cnt=%0d state=%0d expected 4/3", loop_cnt, state_out);
    end
    tests_run++;
    if (loop_cnt_s !== 2'd3) begin
      fails++;
      $display("FAIL loop_saturate: loop_cnt=%0d expected 3", loop_cnt_s);
    end
    // A rejected-looking start while busy must be ignored silently.
    launch(MODE_SINGLE, 8'd6, 8'd2, 24'd1);
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_while_busy: err=%b busy=%b expected 0/1", err, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests_run++;
    if (state_out !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL loop_stop: state=%0d done=%b busy=%b pending=%0d expected 0/0/0/0",
               state_out, done, busy, exp_q.size());
    end
  endtask

  task automatic test_step();
    exp_gap = 0; prev_stb = -1;
    exp_q.push_back(8'd1);
    launch(MODE_STEP, 8'd1, 8'd2, 24'd3);
    repeat (5) tick();
    tests_run++;
    if (state_out !== 8'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL step_hold: state=%0d busy=%b expected 1/1", state_out, busy);
    end
    exp_q.push_back(8'd2);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tests_run++;
    if (state_out !== 8'd2 || step_stb !== 1'b1) begin
      fails++;
      $display("FAIL step_adv: state=%0d stb=%b expected 2/1", state_out, step_stb);
    end
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tests_run++;
    if (done !== 1'b1 || state_out !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL step_done: done=%b state=%0d busy=%b expected 1/0/0", done, state_out, busy);
    end
  endtask

  task automatic test_boundaries();
    // dwell=0 runs one cycle per state; reserved mode 3 behaves as SINGLE.
    exp_gap = 1; prev_stb = -1;
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd8);
    launch(2'd3, 8'd7, 8'd8, 24'd0);
    wait_done("dwell_zero_len", 2);
    exp_gap = 0;
    launch(MODE_SINGLE, 8'd6, 8'd2, 24'd4);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL reversed_range: err=%b busy=%b done=%b expected 1/0/1", err, busy, done);
    end
    tick();
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_width: err=%b expected 0", err);
    end
    launch(MODE_LOOP, 8'd0, 8'd9, 24'd4);
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL last_out_of_range: err=%b busy=%b expected 1/0", err, busy);
    end
    mode = MODE_SINGLE; first_step = 8'd0; last_step = 8'd3;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || err !== 1'b0 || step_stb !== 1'b0 || state_out !== 8'd0) begin
      fails++;
      $display("FAIL start_stop_same: busy=%b err=%b stb=%b state=%0d expected 0/0/0/0",
               busy, err, step_stb, state_out);
    end
  endtask

  task automatic test_reset_midrun();
    exp_gap = DEFAULT_DWELL; prev_stb = -1;
    exp_q.push_back(8'd0);
    launch(MODE_SINGLE, 8'd0, 8'd8, 24'(DEFAULT_DWELL));
    repeat (499) tick();
    reset_n = 1'b0;
    tick();
    check_all_zero("reset_midrun");
    reset_n = 1'b1;
    tick();
    exp_gap = 5; prev_stb = -1;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd3);
    launch(MODE_SINGLE, 8'd2, 8'd3, 24'd5);
    wait_done("after_reset_len", 10);
    tests_run++;
    if (state_out !== 8'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL after_reset_end: state=%0d pending=%0d expected 0/0", state_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_loop();
    test_step();
    test_boundaries();
    test_reset_midrun();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 1 ms simulated");
    $fatal(1, "timeout");
  end

endmodule
